load_store_memory: RTL and testbench
====================================

LOAD_STORE_MEMORY -- requirements
Module: load_store_memory

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits; only 32 is supported.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, number of words; must be a power of two, 4 to 4096.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: a request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2 bits: access size, 0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-009 SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend the load, 0 = sign-extend it.
REQ-010 SHALL have port req_addr, input, 32 bits: byte address.
REQ-011 SHALL have port req_wdata, input, 32 bits: store data, taken LSB-aligned.
REQ-012 SHALL have port rsp_valid, output, 1 bit: response present, one-cycle pulse per accepted request.
REQ-013 SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_error, output, 1 bit: request was misaligned, out of range or used an illegal size.
REQ-015 SHALL have port init_done, output, 1 bit: the post-reset memory clear is complete.

Function
REQ-016 SHALL accept a request on any rising edge where req_valid and req_ready are both 1.
REQ-017 SHALL hold req_ready = 1 only in state READY.
REQ-018 SHALL have a two-state FSM: CLEAR -> READY when the clear counter reaches MEM_DEPTH-1; READY -> CLEAR only on reset.
REQ-019 SHALL, in CLEAR, write 0 to word clr_cnt each cycle, incrementing clr_cnt from 0, so the clear takes exactly MEM_DEPTH cycles.
REQ-020 SHALL set init_done = 1 in the same cycle that req_ready first rises.
REQ-021 SHALL compute the word index as req_addr[log2(MEM_DEPTH)+1:2] and the byte lane as req_addr[1:0].
REQ-022 SHALL flag an error when req_size = 3.
REQ-023 SHALL flag an error for a half access with req_addr[0] = 1.
REQ-024 SHALL flag an error for a word access with req_addr[1:0] != 0.
REQ-025 SHALL flag an error when req_addr >= 4*MEM_DEPTH.
REQ-026 SHALL leave memory unmodified on any erroring store.
REQ-027 SHALL, on a store, update only the addressed lanes at the accept edge: byte from req_wdata[7:0], half from req_wdata[15:0], word from all 32 bits.
REQ-028 SHALL register the response with fixed latency 1: rsp_valid, rsp_rdata and rsp_error are valid in the cycle after acceptance.
REQ-029 SHALL, for a load, extract the addressed lanes and extend them to 32 bits per req_unsigned.
REQ-030 SHALL sustain back-to-back requests at one per cycle.
REQ-031 SHALL return the newly stored value for a load accepted the cycle after a store to the same word.
REQ-032 SHALL emit no response and make no memory change for req_valid while req_ready = 0; no stall or backpressure exists on the response side.

Reset
REQ-033 SHALL, while reset = 1, force FSM = CLEAR, clr_cnt = 0, req_ready = 0, init_done = 0, rsp_valid = 0, rsp_error = 0 and rsp_rdata = 0, asynchronously.
REQ-034 SHALL drop any in-flight response on reset asserted mid-operation, restart the full clear after release, and never produce a partial response.
REQ-035 SHALL make memory contents undefined only until the clear completes; no initial-block initialisation is permitted.

Structure
REQ-036 SHALL take the size encodings SIZE_B/SIZE_H/SIZE_W and the FSM state type from a shared package, mem_pkg.
REQ-037 SHALL place lane extraction plus sign/zero extension in one sub-module, load_align, which is reused by the future cache.
REQ-038 SHALL keep the storage array as four byte-wide lanes so the code infers RAM with byte enables.

Verification
REQ-039 SHALL test: reset release, then count cycles -> req_ready rises exactly MEM_DEPTH cycles later; a load of addr 0x0 returns 0.
REQ-040 SHALL test: store word 0x8000_00F0 @0x10, then load byte @0x10 signed and unsigned -> 0xFFFF_FFF0 and 0x0000_00F0.
REQ-041 SHALL test: store half 0xBEEF @0x22 over word 0x1234_5678 @0x20, then load word @0x20 -> 0xBEEF_5678.
REQ-042 SHALL test: load word @0x13, store half @0x21, access @4*MEM_DEPTH, size 3 -> rsp_error = 1, rdata 0, memory unchanged.
REQ-043 SHALL test: back-to-back store 0xA5A5_A5A5 @0x40 then load word @0x40 on consecutive edges -> rsp_valid two consecutive cycles, second rdata 0xA5A5_A5A5.
REQ-044 SHALL test: reset asserted in the cycle after a load accept -> no rsp_valid; the clear reruns and the prior store data reads 0 afterwards.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared access-size encodings, FSM state type and lane helpers for the
// load/store memory and its future cache sibling.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'd0,
    SIZE_H   = 2'd1,
    SIZE_W   = 2'd2,
    SIZE_BAD = 2'd3
  } size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Byte-lane enable mask for a store of the given size at the given lane.
  function automatic logic [3:0] lane_enable(input size_e size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << lane;
      SIZE_H:  be = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a 32-bit memory word and sign- or
// zero-extends it to a full word.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  size_e       size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = word[8*lane +: 8];
  assign half_s = lane[1] ? word[31:16] : word[15:0];

  // Extend the selected lanes; an illegal size yields zero.
  always_comb begin
    data = 32'd0;
    case (size)
      SIZE_B:  data = is_unsigned ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      SIZE_H:  data = is_unsigned ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      SIZE_W:  data = word;
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_memory.sv
// Byte-addressed load/store scratch memory with a post-reset hardware clear,
// single-cycle request acceptance and a fixed one-cycle registered response.
module load_store_memory
  import mem_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_error,
  output logic             init_done
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] CNT_LAST = AW'(MEM_DEPTH - 1);
  localparam logic [AW-1:0] CNT_ONE  = AW'(1);

  state_e           state_r;
  logic [AW-1:0]    clr_cnt_r;
  logic             ready_r;
  logic             init_done_r;
  logic             rsp_valid_r;
  logic             rsp_error_r;
  logic [WIDTH-1:0] rsp_rdata_r;

  size_e            size_s;
  logic [AW-1:0]    widx_s;
  logic [1:0]       lane_s;
  logic             accept_s;
  logic             err_s;
  logic             out_of_range_s;
  logic [3:0]       wr_en_s;
  logic [31:0]      wr_data_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      load_data_s;

  assign size_s         = size_e'(req_size);
  assign widx_s         = req_addr[AW+1:2];
  assign lane_s         = req_addr[1:0];
  assign accept_s       = req_valid & ready_r;
  assign out_of_range_s = |(req_addr >> (AW + 2));

  // Illegal size, misalignment or an address past the array end is an error.
  always_comb begin
    err_s = 1'b0;
    case (size_s)
      SIZE_B:  err_s = 1'b0;
      SIZE_H:  err_s = req_addr[0];
      SIZE_W:  err_s = (req_addr[1:0] != 2'b00);
      default: err_s = 1'b1;
    endcase
    if (out_of_range_s) begin
      err_s = 1'b1;
    end else begin
      err_s = err_s;
    end
  end

  // Replicate store data onto every lane; the enables pick the live ones.
  always_comb begin
    wr_data_s = 32'd0;
    case (size_s)
      SIZE_B:  wr_data_s = {4{req_wdata[7:0]}};
      SIZE_H:  wr_data_s = {2{req_wdata[15:0]}};
      SIZE_W:  wr_data_s = req_wdata;
      default: wr_data_s = 32'd0;
    endcase
  end

  assign wr_en_s = {4{accept_s & req_write & ~err_s}} & lane_enable(size_s, lane_s);

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [7:0] lane_r [MEM_DEPTH];

    // One byte-wide RAM per lane; the clear sweep has priority over stores.
    always_ff @(posedge clk) begin
      if (state_r == CLEAR) begin
        lane_r[clr_cnt_r] <= 8'd0;
      end else if (wr_en_s[g]) begin
        lane_r[widx_s] <= wr_data_s[8*g +: 8];
      end
    end

    assign rd_word_s[8*g +: 8] = lane_r[widx_s];
  end

  load_align u_load_align (
    .word        (rd_word_s),
    .lane        (lane_s),
    .size        (size_s),
    .is_unsigned (req_unsigned),
    .data        (load_data_s)
  );

  // Clear/ready FSM plus the registered response stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= CLEAR;
      clr_cnt_r   <= '0;
      ready_r     <= 1'b0;
      init_done_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_error_r <= 1'b0;
      rsp_rdata_r <= '0;
    end else begin
      case (state_r)
        CLEAR: begin
          if (clr_cnt_r == CNT_LAST) begin
            state_r     <= READY;
            ready_r     <= 1'b1;
            init_done_r <= 1'b1;
          end else begin
            clr_cnt_r <= clr_cnt_r + CNT_ONE;
          end
        end
        READY: begin
          ready_r     <= 1'b1;
          init_done_r <= 1'b1;
        end
        default: begin
          state_r <= CLEAR;
          ready_r <= 1'b0;
        end
      endcase
      rsp_valid_r <= accept_s;
      rsp_error_r <= accept_s & err_s;
      rsp_rdata_r <= (accept_s && !err_s && !req_write) ? load_data_s : '0;
    end
  end

  assign req_ready = ready_r;
  assign init_done = init_done_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_error = rsp_error_r;
  assign rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_load_store_memory.sv
// Scoreboard bench for load_store_memory: a byte-array reference model feeds an
// expected-response queue that a negedge monitor drains against the DUT.
module tb_load_store_memory;

  localparam int DEPTH = 64;
  localparam int BYTES = 4 * DEPTH;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        init_done;

  int   total = 0;
  int   bad = 0;
  rsp_t exp_q[$];
  logic [7:0] mem_m [BYTES];

  always #5 clk = ~clk;

  load_store_memory #(.WIDTH(32), .MEM_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_error    (rsp_error),
    .init_done    (init_done)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Monitor: every DUT response must match the oldest expected one.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rdata %h err %b want no response", rsp_rdata, rsp_error);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
        check("rsp_rdata", rsp_rdata, e.data);
      end
    end
  end

  // Drive one request; if it will be accepted, record the model's response.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic force_exp, input logic [31:0] exp_data);
    rsp_t   e;
    int     nb;
    longint v;
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    if (req_ready) begin
      nb     = 1 << sz;
      e.err  = (sz == 2'd3) || (addr >= 32'(BYTES)) || ((addr % nb) != 0);
      e.data = 32'd0;
      if (!e.err && wr) begin
        for (int i = 0; i < nb; i++) mem_m[addr + i] = wd[8*i +: 8];
      end else if (!e.err) begin
        v = 0;
        for (int i = 0; i < nb; i++) v = v | (longint'(mem_m[addr + i]) << (8 * i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8 * nb));
        e.data = v[31:0];
      end
      if (force_exp) e.data = exp_data;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Release reset while poking a store at 0x10, and time the clear sweep.
  task automatic release_and_wait(input string name);
    int n;
    @(negedge clk);
    reset     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h10;
    req_wdata = 32'hFFFF_FFFF;
    n = 0;
    while (!req_ready && n < DEPTH + 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    check(name, 32'(n), 32'(DEPTH));
    check({name, "_init_done"}, {31'd0, init_done}, 32'd1);
    for (int i = 0; i < BYTES; i++) mem_m[i] = 8'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < BYTES; i++) mem_m[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    release_and_wait("clear_cycles");

    issue(1'b0, 2'd2, 1'b0, 32'h0,  32'd0, 1'b1, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 32'h0);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h8000_00F0, 1'b0, 32'd0);
    issue(1'b0, 2'd0, 1'b0, 32'h10, 32'd0, 1'b1, 32'hFFFF_FFF0);
    issue(1'b0, 2'd0, 1'b1, 32'h10, 32'd0, 1'b1, 32'h0000_00F0);
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h1234_5678, 1'b0, 32'd0);
    issue(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_BEEF, 1'b0, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b1, 32'hBEEF_5678);
    issue(1'b0, 2'd2, 1'b0, 32'h13, 32'd0, 1'b1, 32'h0);
    issue(1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFF_FFFF, 1'b1, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'(BYTES), 32'd0, 1'b1, 32'h0);
    issue(1'b1, 2'd0, 1'b0, 32'(BYTES) + 32'h3, 32'hFFFF_FFFF, 1'b1, 32'h0);
    issue(1'b0, 2'd3, 1'b0, 32'h20, 32'd0, 1'b1, 32'h0);
    issue(1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFF_FFFF, 1'b1, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, 1'b1, 32'hBEEF_5678);
    idle(2);

    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'hA5A5_A5A5, 1'b0, 32'd0);
    check("b2b_first_valid", {31'd0, rsp_valid}, 32'd1);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b1, 32'hA5A5_A5A5);
    check("b2b_second_valid", {31'd0, rsp_valid}, 32'd1);
    idle(1);

    for (int k = 0; k < 300; k++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, BYTES - 1));
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~(32'(1 << sz) - 32'd1);
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, 32'd0);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(2);

    issue(1'b1, 2'd2, 1'b0, 32'h80, 32'hDEAD_BEEF, 1'b0, 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h80, 32'd0, 1'b1, 32'hDEAD_BEEF);
    reset     = 1'b1;
    req_valid = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_ready", {31'd0, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_init_done", {31'd0, init_done}, 32'd0);
    release_and_wait("reclear_cycles");
    issue(1'b0, 2'd2, 1'b0, 32'h80, 32'd0, 1'b1, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 1'b1, 32'h0);
    issue(1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 1'b1, 32'h0);
    idle(3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
